// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC neuron engine: FSM states, default
// widths and a signed saturation helper.
package mac_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ROUND, OUT} state_t;

  localparam int DEF_DATA_W    = 18;
  localparam int DEF_WEIGHT_W  = 18;
  localparam int DEF_NUM_IN    = 64;
  localparam int DEF_ACC_W     = 48;
  localparam int DEF_OUT_W     = 18;
  localparam int DEF_FRAC_BITS = 8;

  // Working width for the rounding path; ACC_W must leave two bits of headroom.
  localparam int WIDE_W = 64;

  typedef struct packed {
    logic [WIDE_W-1:0] val;
    logic              clip;
  } sat_t;

  // Clamp v into the signed out_w range; clip reports whether clamping happened.
  function automatic sat_t sat_signed(input logic signed [WIDE_W-1:0] v, input int out_w);
    logic signed [WIDE_W-1:0] hi, lo;
    sat_t res;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.val  = v;
    res.clip = 1'b0;
    if (v > hi) begin
      res.val  = hi;
      res.clip = 1'b1;
    end else if (v < lo) begin
      res.val  = lo;
      res.clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_weight_ram.sv
// Single-port weight RAM, synchronous read, read-first on write.
module mac_weight_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  // Sized to the full address space so any addr is a legal index; only DEPTH entries are used.
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mac_neuron_engine.sv
// Streaming neuron MAC: sum(x[i]*w[i]) + bias, rounded, shifted and saturated.
// Define MAC_RELU_EN to clamp negative results to zero.
module mac_neuron_engine
  import mac_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WEIGHT_W  = DEF_WEIGHT_W,
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  localparam int ADDR_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_we,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [WEIGHT_W-1:0] w_data,
  input  logic                b_we,
  input  logic [ACC_W-1:0]    b_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                busy,
  output logic                sat
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_IN - 1);
  localparam logic signed [WIDE_W-1:0] RND = (64'sd1 <<< FRAC_BITS) >>> 1;

  if (ACC_W < PROD_W + $clog2(NUM_IN) || ACC_W > WIDE_W - 2) begin : g_acc_w_check
    $error("mac_neuron_engine: ACC_W out of range for DATA_W/WEIGHT_W/NUM_IN");
  end

  state_t                    state, state_nx;
  logic [ADDR_W-1:0]         cnt, cnt_nx;
  logic                      wr_q;
  logic signed [PROD_W-1:0]  prod;
  logic                      prod_vld;
  logic signed [ACC_W-1:0]   acc, bias;
  logic [WEIGHT_W-1:0]       w_q;
  logic                      idle, accept, done;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic signed [WIDE_W-1:0]  s, r;
  sat_t                      sr;
  logic [OUT_W-1:0]          res_data;
  logic                      res_sat;
  logic                      unused_hi;

  assign idle   = (state == IDLE);
  assign busy   = !idle;
  // The cycle after a weight write the RAM re-reads w[0], so hold off beats until it lands.
  assign in_ready = rst && ((state == RUN) || (idle && !w_we && !b_we && !wr_q));
  assign accept = in_valid && in_ready;
  assign done   = out_valid && out_ready;

  assign ram_we   = w_we && idle;
  assign ram_addr = ram_we ? w_addr : cnt_nx;

  mac_weight_ram #(
    .DEPTH (NUM_IN),
    .WIDTH (WEIGHT_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(w_data),
    .rdata(w_q)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          if (cnt == LAST) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end else begin
            state_nx = RUN;
            cnt_nx   = cnt + ADDR_W'(1);
          end
        end
      end
      DRAIN:   state_nx = ROUND;
      ROUND:   state_nx = OUT;
      OUT: begin
        if (done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s  = WIDE_W'(acc) + WIDE_W'(bias) + RND;
    r  = s >>> FRAC_BITS;
    sr = sat_signed(r, OUT_W);
    res_data = sr.val[OUT_W-1:0];
    res_sat  = sr.clip;
`ifdef MAC_RELU_EN
    if (r < 0) begin
      res_data = '0;
      res_sat  = 1'b0;
    end
`endif
  end

  assign unused_hi = ^sr.val[WIDE_W-1:OUT_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      bias      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wr_q     <= w_we;
      prod_vld <= accept;
      if (accept) prod <= $signed(in_data) * $signed(w_q);
      if (done) acc <= '0;
      else if (prod_vld) acc <= acc + ACC_W'(prod);
      if (b_we && idle) bias <= $signed(b_data);
      if (state == ROUND) begin
        out_data <= res_data;
        sat      <= res_sat;
      end
      // out_valid rises one cycle into OUT, after out_data has been registered in ROUND.
      out_valid <= (state == OUT) && !done;
    end
  end

endmodule

// File: doc/mac_neuron_engine.md
Name: mac_neuron_engine

Overview:
- Parametrised successor to the single-shot DSP MAC. Computes one neuron pre-activation: sum(x[i]*w[i]) + bias over NUM_IN streamed inputs.
- Weights are held in an internal writable RAM. The result is rounded, rescaled and saturated to OUT_W.
- Sits between the feature/pixel stream and the activation/next-layer logic of the recognition network.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- DATA_W, 18, signed input activation width
- WEIGHT_W, 18, signed weight width
- NUM_IN, 64, inputs per dot product (>=1); derived ADDR_W = max(1, clog2(NUM_IN))
- ACC_W, 48, signed accumulator and bias width
- OUT_W, 18, signed output width
- FRAC_BITS, 8, arithmetic right shift applied to the final sum (0 allowed)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- w_we  in  1  weight write strobe
- w_addr  in  ADDR_W  weight index
- w_data  in  WEIGHT_W  signed weight
- b_we  in  1  bias write strobe
- b_data  in  ACC_W  signed bias
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- in_data  in  DATA_W  signed activation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  signed result
- busy  out  1  dot product in progress (RUN/DRAIN/ROUND/OUT)
- sat  out  1  current out_data was clipped

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: out_valid=0, out_data=0, in_ready=0, busy=0, sat=0.
  - Internal: state=IDLE, cnt=0, acc=0, product reg=0, bias=0.
  - Weight RAM contents are not reset.
  - Reset mid-operation discards the partial sum.
- States: IDLE, RUN, DRAIN, ROUND, OUT.
- Beat accept: in_valid && in_ready.
- in_ready=1 in IDLE and RUN, except that in IDLE it is forced to 0 in any cycle with w_we or b_we, and in the cycle after a w_we.
- Weight and bias writes take effect only in IDLE. Writes in any other state are ignored.
- Weight RAM: single port, synchronous, read-first. Read address is cnt_next, so the registered weight always equals w[cnt].
- Pipeline:
  - Stage 1: prod <= in_data * w[cnt] (signed, DATA_W+WEIGHT_W bits).
  - Stage 2: acc <= acc + sign_extend(prod).
  - Overflow of ACC_W wraps (two's complement). ACC_W < DATA_W+WEIGHT_W+clog2(NUM_IN) is an elaboration error.
- Transitions:
  - IDLE -> RUN on the first accept, with cnt=1. If NUM_IN=1, go straight to DRAIN.
  - RUN: cnt increments per accept. The accept with cnt==NUM_IN-1 moves to DRAIN.
  - in_valid low in RUN holds state; there is no timeout.
- DRAIN (1 cycle): pipeline empties. Then ROUND.
- ROUND (1 cycle):
  - s = acc + bias + (FRAC_BITS>0 ? 2^(FRAC_BITS-1) : 0).
  - r = s >>> FRAC_BITS.
  - If r exceeds the signed OUT_W range, clip to max/min and set sat=1; otherwise sat=0.
  - Register out_data.
  - Then OUT.
- OUT:
  - out_valid=1; out_data and sat are held stable until out_ready.
  - On handshake: out_valid=0, acc=0, cnt=0, go to IDLE. in_ready returns the following cycle.
- Latency: the edge accepting the final beat is k; out_valid is high after edge k+3.
- Throughput: one beat per cycle in RUN; NUM_IN+4 cycles minimum per result.
- busy=1 in every state except IDLE.

Optional Feature:
- MAC_RELU_EN defined: in ROUND, a negative r gives out_data=0 with sat=0; positive clipping is unchanged.
- Undefined: signed output, as described above.

Decomposition:
- Package mac_pkg: state enum (IDLE, RUN, DRAIN, ROUND, OUT), default width constants, and a signed saturate function (in width -> OUT_W, returns value and clip flag).
- Sub-module mac_weight_ram: single-port, read-first, synchronous-read RAM, depth NUM_IN, width WEIGHT_W.

Test Plan:
1. NUM_IN=4, FRAC_BITS=0, w={1,2,3,4}, bias=10, x={1,1,1,1} back-to-back -> out_data=20, sat=0; out_valid exactly 3 edges after the 4th accept.
2. Same setup, in_valid toggled every other cycle and out_ready held low 5 cycles -> out_data=20 held stable with out_valid=1 throughout; in_ready=0 until the handshake.
3. FRAC_BITS=8, OUT_W=18, w[i]=131071, x[i]=131071 for all 4 beats -> positive clip: out_data=131071, sat=1. A second run with x negated -> out_data=-131072, sat=1.
4. FRAC_BITS=1, NUM_IN=1, w=3, x=1, bias=0 -> s=3+1=4, out_data=2. Repeat with bias=-6 -> s=-3+1=-2, out_data=-1.
5. w_we pulsed in RUN (addr 0, data 99) -> ignored; result unchanged. w_we in IDLE coincident with in_valid -> in_ready low that cycle and the next; the subsequent run uses the new weight.
6. rst asserted during RUN after 2 beats -> immediate out_valid=0, busy=0. After release, a full run gives the correct result with no residue from the partial sum.
7. MAC_RELU_EN: negative sum of -50 -> out_data=0, sat=0.
